// File: rtl/seq_ctrl.sv
//==============================================================================
// Module      : seq_ctrl
// Description : Multi-cycle instruction sequencer (IDLE/FETCH/EXEC/MEM/WB/PCUP/
//               HALTED) with fault capture, stage strobes and retire counting.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_ctrl #(
  parameter logic [63:0] RESET_PC = 64'd32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        step_mode,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        dmem_error,
  input  logic [63:0] updated_pc,
  output logic [63:0] PC,
  output logic        fetch_en,
  output logic        exec_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        pc_en,
  output logic [1:0]  stat,
  output logic        busy,
  output logic        done,
  output logic [31:0] instr_count
);

  localparam logic [1:0] c_STAT_AOK = 2'd0;
  localparam logic [1:0] c_STAT_HLT = 2'd1;
  localparam logic [1:0] c_STAT_ADR = 2'd2;
  localparam logic [1:0] c_STAT_INS = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_PCUP   = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_pc;
  logic [1:0]  r_stat;
  logic [31:0] r_count;
  logic        r_done;

  logic        w_pc_load;
  logic        w_cnt_inc;
  logic        w_stat_load;
  logic [1:0]  w_stat_val;
  logic        w_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_stat  <= c_STAT_AOK;
      r_count <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done;
      if (w_pc_load)
        r_pc <= updated_pc;
      if (w_stat_load)
        r_stat <= w_stat_val;
      // Retire counter sticks at all-ones instead of wrapping
      if (w_cnt_inc && (r_count != 32'hFFFF_FFFF))
        r_count <= r_count + 32'd1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pc_load   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_stat_load = 1'b0;
    w_stat_val  = r_stat;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start)
          w_next = S_FETCH;
      end
      S_FETCH: begin
        // Address fault outranks illegal instruction, which outranks halt
        if (imem_error) begin
          w_next      = S_HALTED;
          w_stat_load = 1'b1;
          w_stat_val  = c_STAT_ADR;
          w_done      = 1'b1;
        end else if (!instr_valid) begin
          w_next      = S_HALTED;
          w_stat_load = 1'b1;
          w_stat_val  = c_STAT_INS;
          w_done      = 1'b1;
        end else if (icode == 4'h0) begin
          w_next      = S_HALTED;
          w_stat_load = 1'b1;
          w_stat_val  = c_STAT_HLT;
          w_cnt_inc   = 1'b1;
          w_done      = 1'b1;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: w_next = S_MEM;
      S_MEM: begin
        if (dmem_error) begin
          w_next      = S_HALTED;
          w_stat_load = 1'b1;
          w_stat_val  = c_STAT_ADR;
          w_done      = 1'b1;
        end else begin
          w_next = S_WB;
        end
      end
      S_WB: w_next = S_PCUP;
      S_PCUP: begin
        w_pc_load = 1'b1;
        w_cnt_inc = 1'b1;
        if (step_mode) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_HALTED: w_next = S_HALTED;
      default:  w_next = S_IDLE;
    endcase
  end

  assign fetch_en    = (r_state == S_FETCH);
  assign exec_en     = (r_state == S_EXEC);
  assign mem_en      = (r_state == S_MEM);
  assign wb_en       = (r_state == S_WB);
  assign pc_en       = (r_state == S_PCUP);
  assign busy        = fetch_en | exec_en | mem_en | wb_en | pc_en;
  assign PC          = r_pc;
  assign stat        = r_stat;
  assign done        = r_done;
  assign instr_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_seq_ctrl.sv
//==============================================================================
// Module      : tb_seq_ctrl
// Description : Directed plus randomized bench for seq_ctrl against a
//               per-instruction outcome model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        step_mode = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic        instr_valid = 1'b1;
  logic        imem_error = 1'b0;
  logic        dmem_error = 1'b0;
  logic [63:0] updated_pc = 64'd0;
  logic [63:0] PC;
  logic        fetch_en, exec_en, mem_en, wb_en, pc_en;
  logic [1:0]  stat;
  logic        busy, done;
  logic [31:0] instr_count;

  int checks = 0;
  int failures = 0;

  logic [63:0] m_pc;
  logic [31:0] m_count;
  logic [1:0]  m_stat;

  // Instruction outcomes
  localparam int F_NORMAL = 0;
  localparam int F_HALT   = 1;
  localparam int F_IMEM   = 2;
  localparam int F_INV    = 3;
  localparam int F_BOTH   = 4;
  localparam int F_DMEM   = 5;

  seq_ctrl #(.RESET_PC(64'd32)) dut (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode),
    .icode(icode), .instr_valid(instr_valid), .imem_error(imem_error),
    .dmem_error(dmem_error), .updated_pc(updated_pc), .PC(PC),
    .fetch_en(fetch_en), .exec_en(exec_en), .mem_en(mem_en), .wb_en(wb_en),
    .pc_en(pc_en), .stat(stat), .busy(busy), .done(done),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {fetch_en, exec_en, mem_en, wb_en, pc_en};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_strobes"}, {59'd0, strobes()}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_pc"}, PC, 64'd32);
    chk({tag, "_stat"}, {62'd0, stat}, 64'd0);
    chk({tag, "_count"}, {32'd0, instr_count}, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk_reset_vals("reset");
    m_pc = 64'd32; m_count = 32'd0; m_stat = 2'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic begin_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs one instruction from FETCH and checks its whole trace plus the outcome.
  task automatic do_instr(input int fate, input bit step, input logic [63:0] upc,
                          output bit stopped);
    int n;
    bit halted, idle;
    icode       = (fate == F_HALT) ? 4'h0 : 4'($urandom_range(1, 15));
    instr_valid = !(fate == F_INV || fate == F_BOTH);
    imem_error  = (fate == F_IMEM || fate == F_BOTH);
    dmem_error  = (fate == F_DMEM);
    step_mode   = step;
    updated_pc  = upc;
    n = (fate == F_NORMAL) ? 5 : (fate == F_DMEM) ? 3 : 1;
    for (int k = 0; k < n; k++) begin
      chk("stage_strobe", {59'd0, strobes()}, {59'd0, 5'b10000 >> k});
      chk("stage_busy", {63'd0, busy}, 64'd1);
      chk("stage_done", {63'd0, done}, 64'd0);
      chk("stage_pc", PC, m_pc);
      start = 1'($urandom);
      tick();
    end
    start = 1'b0;
    halted = (fate != F_NORMAL);
    idle   = (fate == F_NORMAL) && step;
    case (fate)
      F_NORMAL: begin m_pc = upc; if (m_count != 32'hFFFF_FFFF) m_count++; end
      F_HALT:   begin m_stat = 2'd1; if (m_count != 32'hFFFF_FFFF) m_count++; end
      F_INV:    m_stat = 2'd3;
      default:  m_stat = 2'd2;
    endcase
    chk("end_pc", PC, m_pc);
    chk("end_count", {32'd0, instr_count}, {32'd0, m_count});
    chk("end_stat", {62'd0, stat}, {62'd0, m_stat});
    chk("end_done", {63'd0, done}, {63'd0, (halted || idle)});
    chk("end_busy", {63'd0, busy}, {63'd0, !(halted || idle)});
    dmem_error = 1'b0; imem_error = 1'b0; instr_valid = 1'b1;
    if (halted) begin
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      chk("halt_done", {63'd0, done}, 64'd0);
      chk("halt_strobes", {59'd0, strobes()}, 64'd0);
      chk("halt_stat", {62'd0, stat}, {62'd0, m_stat});
      chk("halt_pc", PC, m_pc);
    end
    stopped = halted;
  endtask

  task automatic idle_wait(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      tick();
      chk("idle_strobes", {59'd0, strobes()}, 64'd0);
      chk("idle_done", {63'd0, done}, 64'd0);
      chk("idle_pc", PC, m_pc);
    end
  endtask

  initial begin
    bit stopped;
    int fate, r;
    bit step;

    // Halt program: nop then halt
    do_reset();
    begin_run();
    do_instr(F_NORMAL, 1'b0, 64'd33, stopped);
    do_instr(F_HALT, 1'b0, 64'd99, stopped);

    // Fetch faults and their priority
    do_reset();
    begin_run();
    do_instr(F_IMEM, 1'b0, 64'd77, stopped);
    do_reset();
    begin_run();
    do_instr(F_INV, 1'b0, 64'd77, stopped);
    do_reset();
    begin_run();
    do_instr(F_BOTH, 1'b0, 64'd77, stopped);

    // Data fault after one retired instruction
    do_reset();
    begin_run();
    do_instr(F_NORMAL, 1'b0, 64'd100, stopped);
    do_instr(F_DMEM, 1'b0, 64'd200, stopped);

    // Single-step and resume from the held PC
    do_reset();
    begin_run();
    do_instr(F_NORMAL, 1'b1, 64'd42, stopped);
    idle_wait(3);
    begin_run();
    do_instr(F_NORMAL, 1'b1, 64'd50, stopped);

    // Asynchronous reset while in MEM
    do_reset();
    begin_run();
    tick();
    tick();
    chk("pre_abort_mem", {59'd0, strobes()}, 64'h4);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_vals("abort");
    m_pc = 64'd32; m_count = 32'd0; m_stat = 2'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    begin_run();
    do_instr(F_NORMAL, 1'b0, 64'd77, stopped);

    // Randomized programs
    for (int t = 0; t < 25; t++) begin
      do_reset();
      begin_run();
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 15);
        fate = (r < 9) ? F_NORMAL : (r - 9 > 5) ? F_HALT : r - 9;
        step = 1'($urandom);
        do_instr(fate, step, {$urandom, $urandom}, stopped);
        if (stopped) break;
        if (fate == F_NORMAL && step) begin
          idle_wait($urandom_range(0, 3));
          begin_run();
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'd32, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  begin execution; sampled only in IDLE.
REQ-005 SHALL have port step_mode  input  1  1: return to IDLE after each retired instruction; sampled in PCUP.
REQ-006 SHALL have port icode  input  4  from fetch stage.
REQ-007 SHALL have port instr_valid  input  1  from fetch; 0 = illegal instruction.
REQ-008 SHALL have port imem_error  input  1  from fetch; instruction address fault.
REQ-009 SHALL have port dmem_error  input  1  from memory stage; data address fault.
REQ-010 SHALL have port updated_pc  input  64  next PC from pc_update.
REQ-011 SHALL have port PC  output  64  current instruction address driven to fetch.
REQ-012 SHALL have ports fetch_en, exec_en, mem_en, wb_en, pc_en  output  1 each  one-hot stage strobes.
REQ-013 SHALL have port stat  output  2  0 AOK, 1 HLT, 2 ADR, 3 INS.
REQ-014 SHALL have port busy  output  1  high in FETCH, EXEC, MEM, WB, PCUP.
REQ-015 SHALL have port done  output  1  one-cycle pulse on leaving a run.
REQ-016 SHALL have port instr_count  output  32  retired-instruction count.

Function
REQ-017 SHALL implement states IDLE, FETCH, EXEC, MEM, WB, PCUP, HALTED.
REQ-018 SHALL decode strobes from the state register only: fetch_en=FETCH, exec_en=EXEC, mem_en=MEM, wb_en=WB, pc_en=PCUP; all 0 in IDLE/HALTED.
REQ-019 SHALL go IDLE->FETCH on an edge with start=1; start ignored in all other states.
REQ-020 SHALL advance FETCH->EXEC->MEM->WB->PCUP, one cycle each; a normal instruction occupies exactly 5 cycles.
REQ-021 SHALL evaluate faults on the edge leaving FETCH in priority order: imem_error (stat=2), else instr_valid=0 (stat=3), else icode=4'h0 (stat=1); any of these -> HALTED.
REQ-022 SHALL increment instr_count on halt (icode 0, no higher-priority fault); SHALL NOT increment on imem_error or instr_valid=0.
REQ-023 SHALL, on the edge leaving MEM with dmem_error=1, set stat=2 and go HALTED; WB and PCUP skipped.
REQ-024 SHALL, on the edge leaving PCUP, load PC<=updated_pc and increment instr_count; then FETCH if step_mode=0, IDLE if step_mode=1.
REQ-025 SHALL leave PC unchanged on every fault or halt path.
REQ-026 SHALL saturate instr_count at 32'hFFFF_FFFF (no wrap).
REQ-027 SHALL pulse done for exactly one cycle after any transition into HALTED or PCUP->IDLE.
REQ-028 SHALL leave HALTED only via reset; stat holds its value.
REQ-029 SHALL leave PC, instr_count and stat unchanged in IDLE, so a later start resumes at the held PC.

Reset
REQ-030 SHALL, while reset=1, immediately (no clock edge needed) force state=IDLE, PC=RESET_PC, stat=0, instr_count=0, done=0, busy=0, all strobes 0.
REQ-031 SHALL abort any in-flight instruction when reset is asserted mid-run; no PC or count update from that instruction.
REQ-032 SHALL accept start on the first rising edge after reset deasserts.

Verification
REQ-033 Reset; start; fetch returns nop (icode 1) then halt (icode 0), updated_pc=33 -> PC 32->33 after 5 cycles, then stat=1, instr_count=2, PC=33, one done pulse, HALTED.
REQ-034 imem_error=1 in first FETCH -> stat=2, exec_en never asserted, PC=32, instr_count=0, done pulses once.
REQ-035 instr_valid=0 with imem_error=0 in FETCH -> stat=3; with both asserted -> stat=2 (priority).
REQ-036 dmem_error=1 during MEM -> stat=2, wb_en and pc_en never asserted, PC unchanged, instr_count unchanged.
REQ-037 step_mode=1, start, updated_pc=42 -> one 5-cycle instruction, PC=42, instr_count=1, IDLE, busy=0, done pulses once; second start runs next instruction from 42.
REQ-038 Assert reset mid-cycle while in MEM -> outputs return to reset values before next clk edge; start afterwards fetches from PC=32.
